// File: rtl/serial_link_pkg.sv
// Shared types and helpers for the serial ALU word link.
package serial_link_pkg;

    localparam int ALU_WORD_W   = 10;
    localparam int PARITY_MAX_W = 64;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SHIFT,
        TX_GAP
    } tx_state_t;

    // Callers zero-extend narrower words; the padding cannot change the XOR.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/serial_word_link_if.sv
// Host-side word interface of the serial link: TX push port, RX ready/valid port, status.
interface serial_word_link_if
    import serial_link_pkg::*;
#(
    parameter int WORD_W   = ALU_WORD_W,
    parameter int TX_DEPTH = 4
) ();
    localparam int LVL_W = $clog2(TX_DEPTH) + 1;

    logic [WORD_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [LVL_W-1:0]  tx_level;
    logic              tx_busy;
    logic [WORD_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              rx_parity_err;
    logic              rx_frame_err;
    logic              rx_overrun;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, tx_level, tx_busy,
        input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, tx_level, tx_busy,
        output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
    );

endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO, fall-through read of the head entry.
// Latency: a pushed word is visible at pop_dat the cycle after the push edge.
// Backpressure: full blocks a push unless a pop happens on the same edge; pop on empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;

endmodule

// File: rtl/serial_word_link.sv
// Serial word transceiver: buffered MSB-first TX under ser_en_n, framed RX with even-parity check.
// Latency: TX first bit one edge after the word is queued; RX word on the edge sampling its last bit.
// Backpressure: tx_ready drops when the FIFO is full; an RX word completing while rx_data is unread is dropped.
module serial_word_link
    import serial_link_pkg::*;
#(
    parameter int WORD_W    = ALU_WORD_W,
    parameter int TX_DEPTH  = 4,
    parameter int IFG       = 1,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    serial_word_link_if.slave host,
    output logic              ser_out,
    output logic              ser_en_n,
    input  logic              ser_in,
    input  logic              ser_in_valid
);
    localparam int BC_W = $clog2(WORD_W);
    localparam int GC_W = (IFG > 1) ? $clog2(IFG) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);
    localparam logic [GC_W-1:0] LAST_GAP = GC_W'(IFG - 1);

    tx_state_t         tx_state;
    logic [WORD_W-1:0] tx_sreg;
    logic [BC_W-1:0]   tx_bit_cnt;
    logic [GC_W-1:0]   gap_cnt;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_dat;

    assign fifo_push     = host.tx_valid && host.tx_ready;
    assign host.tx_ready = !fifo_full;
    assign host.tx_busy  = (tx_state != TX_IDLE) || !fifo_empty;
    // Pops only happen where the FSM is ready to start a word, so a pop always means "load now".
    assign fifo_pop = !fifo_empty &&
                      ((tx_state == TX_IDLE) || (tx_state == TX_GAP && gap_cnt == LAST_GAP));

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (host.tx_data),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (host.tx_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            tx_sreg    <= '0;
            tx_bit_cnt <= '0;
            gap_cnt    <= '0;
            ser_en_n   <= 1'b1;
            ser_out    <= 1'b0;
        end else if (fifo_pop) begin
            tx_state   <= TX_SHIFT;
            tx_sreg    <= {fifo_dat[WORD_W-2:0], 1'b0};
            tx_bit_cnt <= '0;
            ser_en_n   <= 1'b0;
            ser_out    <= fifo_dat[WORD_W-1];
        end else begin
            case (tx_state)
                TX_SHIFT: begin
                    if (tx_bit_cnt == LAST_BIT) begin
                        tx_state <= TX_GAP;
                        gap_cnt  <= '0;
                        ser_en_n <= 1'b1;
                        ser_out  <= 1'b0;
                    end else begin
                        tx_bit_cnt <= tx_bit_cnt + 1'b1;
                        tx_sreg    <= {tx_sreg[WORD_W-2:0], 1'b0};
                        ser_out    <= tx_sreg[WORD_W-1];
                    end
                end
                TX_GAP: begin
                    if (gap_cnt == LAST_GAP) tx_state <= TX_IDLE;
                    else                     gap_cnt  <= gap_cnt + 1'b1;
                end
                TX_IDLE: tx_state <= TX_IDLE;
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    logic [WORD_W-1:0] rx_sreg;
    logic [BC_W-1:0]   rx_cnt;
    logic [WORD_W-1:0] rx_word;
    logic              rx_done;

    assign rx_word = {rx_sreg[WORD_W-2:0], ser_in};
    assign rx_done = ser_in_valid && (rx_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sreg            <= '0;
            rx_cnt             <= '0;
            host.rx_data       <= '0;
            host.rx_valid      <= 1'b0;
            host.rx_parity_err <= 1'b0;
            host.rx_frame_err  <= 1'b0;
            host.rx_overrun    <= 1'b0;
        end else begin
            host.rx_frame_err <= 1'b0;
            host.rx_overrun   <= 1'b0;
            if (ser_in_valid) begin
                rx_sreg <= rx_word;
                rx_cnt  <= rx_done ? '0 : rx_cnt + 1'b1;
            end else if (rx_cnt != '0) begin
                host.rx_frame_err <= 1'b1;
                rx_cnt            <= '0;
            end
            // An unread word wins over a new one; a same-cycle accept frees the slot.
            if (rx_done && host.rx_valid && !host.rx_ready) begin
                host.rx_overrun <= 1'b1;
            end else if (rx_done) begin
                host.rx_data       <= rx_word;
                host.rx_valid      <= 1'b1;
                host.rx_parity_err <= (PARITY_EN != 0) && even_parity(PARITY_MAX_W'(rx_word));
            end else if (host.rx_valid && host.rx_ready) begin
                host.rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_link.sv
// Self-checking bench for serial_word_link: scenario tasks against a queue-based serial/word model.
module tb_serial_word_link;

    localparam int W   = 10;
    localparam int D   = 4;
    localparam int IFG = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic ser_out, ser_en_n, ser_in, ser_in_valid;
    logic ser_in_drv = 1'b0;
    logic vld_drv    = 1'b0;
    logic lb         = 1'b0;

    serial_word_link_if #(.WORD_W(W), .TX_DEPTH(D)) bus ();

    serial_word_link #(
        .WORD_W    (W),
        .TX_DEPTH  (D),
        .IFG       (IFG),
        .PARITY_EN (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .host         (bus),
        .ser_out      (ser_out),
        .ser_en_n     (ser_en_n),
        .ser_in       (ser_in),
        .ser_in_valid (ser_in_valid)
    );

    assign ser_in       = lb ? ser_out : ser_in_drv;
    assign ser_in_valid = lb ? ~ser_en_n : vld_drv;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] tx_cap[$];
    int           len_q[$];
    int           gap_q[$];
    logic [W-1:0] rx_cap[$];
    logic         rx_par_q[$];
    int frame_cnt = 0, ovr_cnt = 0, ready_lows = 0, max_level = 0, timeouts = 0;
    logic [31:0] cur = '0;
    int nbits = 0, high_run = 0;
    bit in_word = 0, have_word = 0;

    // Observer: rebuilds serial words and gaps, records RX handshakes and error pulses.
    always @(negedge clk) begin
        if (ser_en_n === 1'b0) begin
            if (!in_word) begin
                if (have_word) gap_q.push_back(high_run);
                in_word = 1;
                nbits   = 0;
                cur     = '0;
            end
            cur = {cur[30:0], ser_out};
            nbits++;
        end else if (in_word) begin
            tx_cap.push_back(cur[W-1:0]);
            len_q.push_back(nbits);
            in_word   = 0;
            have_word = 1;
            high_run  = 1;
        end else begin
            high_run++;
        end
        if (bus.rx_valid && bus.rx_ready) begin
            rx_cap.push_back(bus.rx_data);
            rx_par_q.push_back(bus.rx_parity_err);
        end
        if (bus.rx_frame_err) frame_cnt++;
        if (bus.rx_overrun)   ovr_cnt++;
        if (!rst) begin
            if (int'(bus.tx_level) > max_level) max_level = int'(bus.tx_level);
            total++;
            if (bus.tx_ready !== (int'(bus.tx_level) < D)) begin
                bad++;
                $display("FAIL ready_vs_level tx_ready=%b tx_level=%0d", bus.tx_ready, bus.tx_level);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        tx_cap.delete(); len_q.delete(); gap_q.delete();
        rx_cap.delete(); rx_par_q.delete();
        have_word = 0; frame_cnt = 0; ovr_cnt = 0;
        ready_lows = 0; max_level = 0; timeouts = 0;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        logic rdy;
        int   guard;
        guard = 0;
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        do begin
            rdy = bus.tx_ready;
            if (!rdy) ready_lows++;
            tick();
            guard++;
        end while (!rdy && guard < 200);
        bus.tx_valid = 1'b0;
        if (!rdy) timeouts++;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (bus.tx_busy && guard < 500) begin
            tick();
            guard++;
        end
        if (bus.tx_busy) timeouts++;
    endtask

    task automatic send_rx_bits(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            vld_drv    = 1'b1;
            ser_in_drv = w[W-1-i];
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if (ser_en_n !== 1'b1) begin bad++; $display("FAIL rst_hold ser_en_n got=%b want=1", ser_en_n); end
        rst = 1'b0;
        tick();
        total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL reset tx_ready got=%b want=1", bus.tx_ready); end
        total++; if (bus.tx_level !== 3'd0) begin bad++; $display("FAIL reset tx_level got=%0d want=0", bus.tx_level); end
        total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL reset tx_busy got=%b want=0", bus.tx_busy); end
        total++; if (ser_en_n !== 1'b1) begin bad++; $display("FAIL reset ser_en_n got=%b want=1", ser_en_n); end
        total++; if (ser_out !== 1'b0) begin bad++; $display("FAIL reset ser_out got=%b want=0", ser_out); end
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset rx_valid got=%b want=0", bus.rx_valid); end
        total++; if (bus.rx_data !== '0) begin bad++; $display("FAIL reset rx_data got=%h want=0", bus.rx_data); end
        total++; if ({bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun} !== 3'b000) begin
            bad++; $display("FAIL reset err_flags got=%b want=000", {bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun});
        end
    endtask

    task automatic test_single_word();
        logic [W-1:0] w;
        w = 10'h0F0;
        clear_obs();
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        total++; if (ser_en_n !== 1'b1) begin bad++; $display("FAIL single_accept ser_en_n got=%b want=1", ser_en_n); end
        total++; if (bus.tx_busy !== 1'b1) begin bad++; $display("FAIL single_accept tx_busy got=%b want=1", bus.tx_busy); end
        total++; if (bus.tx_level !== 3'd1) begin bad++; $display("FAIL single_accept tx_level got=%0d want=1", bus.tx_level); end
        tick();
        for (int i = 0; i < W; i++) begin
            total++; if (ser_en_n !== 1'b0) begin bad++; $display("FAIL single_en bit=%0d ser_en_n got=%b want=0", i, ser_en_n); end
            total++; if (ser_out !== w[W-1-i]) begin bad++; $display("FAIL single_bit bit=%0d ser_out got=%b want=%b", i, ser_out, w[W-1-i]); end
            tick();
        end
        total++; if (ser_en_n !== 1'b1) begin bad++; $display("FAIL single_end ser_en_n got=%b want=1", ser_en_n); end
        total++; if (bus.tx_busy !== 1'b1) begin bad++; $display("FAIL single_gap tx_busy got=%b want=1", bus.tx_busy); end
        repeat (IFG) tick();
        total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL single_idle tx_busy got=%b want=0", bus.tx_busy); end
        total++; if (tx_cap.size() != 1 || len_q[0] != W) begin
            bad++; $display("FAIL single_capture words got=%0d want=1", tx_cap.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words[6];
        clear_obs();
        foreach (words[n]) words[n] = W'($urandom);
        foreach (words[n]) push_word(words[n]);
        wait_idle();
        repeat (2) tick();
        total++; if (timeouts != 0) begin bad++; $display("FAIL b2b_timeout got=%0d want=0", timeouts); end
        total++; if (ready_lows == 0) begin bad++; $display("FAIL b2b_backpressure ready_low_cycles got=0 want>0"); end
        total++; if (max_level != D) begin bad++; $display("FAIL b2b_max_level got=%0d want=%0d", max_level, D); end
        total++; if (tx_cap.size() != 6) begin bad++; $display("FAIL b2b_count got=%0d want=6", tx_cap.size()); end
        for (int n = 0; n < 6 && n < tx_cap.size(); n++) begin
            total++; if (tx_cap[n] !== words[n] || len_q[n] != W) begin
                bad++; $display("FAIL b2b_word n=%0d got=%h len=%0d want=%h len=%0d", n, tx_cap[n], len_q[n], words[n], W);
            end
        end
        total++; if (gap_q.size() != 5) begin bad++; $display("FAIL b2b_gaps got=%0d want=5", gap_q.size()); end
        foreach (gap_q[n]) begin
            total++; if (gap_q[n] != IFG) begin bad++; $display("FAIL b2b_gap_len n=%0d got=%0d want=%0d", n, gap_q[n], IFG); end
        end
    endtask

    task automatic test_loopback();
        logic [W-1:0] words[6];
        clear_obs();
        lb = 1'b1;
        bus.rx_ready = 1'b1;
        words[0] = 10'h0F0;
        words[1] = 10'h0F1;
        for (int n = 2; n < 6; n++) words[n] = W'($urandom);
        foreach (words[n]) push_word(words[n]);
        wait_idle();
        repeat (3) tick();
        total++; if (rx_cap.size() != 6) begin bad++; $display("FAIL loop_count got=%0d want=6", rx_cap.size()); end
        for (int n = 0; n < 6 && n < rx_cap.size(); n++) begin
            total++; if (rx_cap[n] !== words[n] || rx_par_q[n] !== ^words[n]) begin
                bad++; $display("FAIL loop_word n=%0d got=%h par=%b want=%h par=%b", n, rx_cap[n], rx_par_q[n], words[n], ^words[n]);
            end
        end
        total++; if (frame_cnt != 0 || ovr_cnt != 0) begin
            bad++; $display("FAIL loop_errors frame=%0d overrun=%0d want=0/0", frame_cnt, ovr_cnt);
        end
        lb = 1'b0;
    endtask

    task automatic test_frame_err();
        logic [W-1:0] w;
        clear_obs();
        bus.rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vld_drv    = 1'b1;
            ser_in_drv = 1'($urandom_range(0, 1));
            tick();
        end
        vld_drv = 1'b0;
        repeat (3) tick();
        total++; if (frame_cnt != 1) begin bad++; $display("FAIL frame_pulse got=%0d want=1", frame_cnt); end
        total++; if (rx_cap.size() != 0 || bus.rx_valid !== 1'b0) begin
            bad++; $display("FAIL frame_discard words=%0d rx_valid=%b want=0/0", rx_cap.size(), bus.rx_valid);
        end
        w = W'($urandom);
        send_rx_bits(w);
        vld_drv = 1'b0;
        repeat (3) tick();
        total++; if (rx_cap.size() != 1) begin bad++; $display("FAIL frame_recover count got=%0d want=1", rx_cap.size()); end
        else begin
            total++; if (rx_cap[0] !== w || rx_par_q[0] !== ^w) begin
                bad++; $display("FAIL frame_recover word got=%h par=%b want=%h par=%b", rx_cap[0], rx_par_q[0], w, ^w);
            end
        end
        total++; if (frame_cnt != 1) begin bad++; $display("FAIL frame_after got=%0d want=1", frame_cnt); end
    endtask

    task automatic test_overrun();
        logic [W-1:0] a, b;
        clear_obs();
        bus.rx_ready = 1'b0;
        a = W'($urandom);
        b = ~a;
        send_rx_bits(a);
        send_rx_bits(b);
        vld_drv = 1'b0;
        repeat (3) tick();
        total++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== a) begin
            bad++; $display("FAIL ovr_hold rx_valid=%b rx_data=%h want 1/%h", bus.rx_valid, bus.rx_data, a);
        end
        total++; if (bus.rx_parity_err !== ^a) begin bad++; $display("FAIL ovr_parity got=%b want=%b", bus.rx_parity_err, ^a); end
        total++; if (ovr_cnt != 1) begin bad++; $display("FAIL ovr_pulse got=%0d want=1", ovr_cnt); end
        total++; if (frame_cnt != 0) begin bad++; $display("FAIL ovr_frame got=%0d want=0", frame_cnt); end
        bus.rx_ready = 1'b1;
        repeat (2) tick();
        bus.rx_ready = 1'b0;
        total++; if (rx_cap.size() != 1 || rx_cap[0] !== a) begin
            bad++; $display("FAIL ovr_read words=%0d want=1 of %h", rx_cap.size(), a);
        end
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_clear rx_valid got=%b want=0", bus.rx_valid); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] p0;
        int lows;
        clear_obs();
        lb = 1'b1;
        bus.rx_ready = 1'b0;
        p0 = W'($urandom);
        push_word(p0);
        wait_idle();
        repeat (2) tick();
        total++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== p0) begin
            bad++; $display("FAIL mid_pre rx_valid=%b rx_data=%h want 1/%h", bus.rx_valid, bus.rx_data, p0);
        end
        push_word(W'($urandom));
        push_word(W'($urandom));
        push_word(W'($urandom));
        repeat (4) tick();
        total++; if (ser_en_n !== 1'b0 || bus.tx_level !== 3'd2) begin
            bad++; $display("FAIL mid_pre_tx ser_en_n=%b tx_level=%0d want 0/2", ser_en_n, bus.tx_level);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (ser_en_n !== 1'b1 || ser_out !== 1'b0) begin
            bad++; $display("FAIL mid_abort ser_en_n=%b ser_out=%b want 1/0", ser_en_n, ser_out);
        end
        total++; if (bus.tx_level !== 3'd0 || bus.tx_ready !== 1'b1 || bus.tx_busy !== 1'b0) begin
            bad++; $display("FAIL mid_flush level=%0d ready=%b busy=%b want 0/1/0", bus.tx_level, bus.tx_ready, bus.tx_busy);
        end
        total++; if (bus.rx_valid !== 1'b0 || bus.rx_data !== '0) begin
            bad++; $display("FAIL mid_rx_clear rx_valid=%b rx_data=%h want 0/0", bus.rx_valid, bus.rx_data);
        end
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ser_en_n !== 1'b1) lows++;
        end
        total++; if (lows != 0) begin bad++; $display("FAIL mid_quiet ser_en_n_low_cycles got=%0d want=0", lows); end
        total++; if (frame_cnt != 0 || ovr_cnt != 0 || bus.rx_valid !== 1'b0) begin
            bad++; $display("FAIL mid_rx_quiet frame=%0d overrun=%0d rx_valid=%b want 0/0/0", frame_cnt, ovr_cnt, bus.rx_valid);
        end
        total++; if (timeouts != 0) begin bad++; $display("FAIL mid_timeout got=%0d want=0", timeouts); end
        lb = 1'b0;
    endtask

    initial begin
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_loopback();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/serial_word_link.md
Name: serial_word_link

Overview:
Synthesisable serial word transceiver for the serial ALU link protocol. It is the parametrised RTL successor of the testbench-only send/receive word tasks.
- TX side: buffers parallel words in a FIFO and shifts each out MSB-first under an active-low enable.
- RX side: deserialises words framed by a valid strobe, checks even parity, and presents them on a ready/valid port.
- Sits between the ALU test harness/host logic and the serial ALU pins.

Parameters:
WORD_W, 10, bits per serial word (>=2).
TX_DEPTH, 4, TX FIFO depth in words; power of 2, >=2.
IFG, 1, minimum idle cycles with ser_en_n high between consecutive TX words (>=1).
PARITY_EN, 1, 1 = RX checks even parity over all WORD_W bits; 0 = rx_parity_err tied 0.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous reset, active high.
tx_data  in  WORD_W  word to transmit.
tx_valid  in  1  tx_data valid.
tx_ready  out  1  FIFO not full; word accepted when tx_valid&&tx_ready at a rising edge.
tx_level  out  $clog2(TX_DEPTH)+1  words currently in FIFO.
tx_busy  out  1  FSM not IDLE or FIFO non-empty.
ser_out  out  1  serial data to DUT.
ser_en_n  out  1  low while a word is being shifted.
ser_in  in  1  serial data from DUT.
ser_in_valid  in  1  high for each valid bit of an incoming word.
rx_data  out  WORD_W  received word, first bit received in MSB.
rx_valid  out  1  rx_data valid; held until rx_ready.
rx_ready  in  1  consumer accepts rx_data.
rx_parity_err  out  1  qualifies rx_data; 1 if XOR of all received bits is 1.
rx_frame_err  out  1  one-cycle pulse: ser_in_valid dropped mid-word.
rx_overrun  out  1  one-cycle pulse: word completed while rx_valid&&!rx_ready.

Behaviour:
- Clock/reset: single clock clk. Synchronous active-high reset rst: all state is updated only on the rising edge of clk, and rst is sampled there; there are no asynchronous paths.
- Reset values:
  - FIFO empty: tx_ready=1, tx_level=0, tx_busy=0.
  - ser_en_n=1, ser_out=0.
  - rx_valid=0, rx_data=0, all error flags 0.
- Reset mid-word aborts the transfer. ser_en_n goes high on the edge where rst is sampled. The FIFO is flushed and the RX shift register is discarded.
- TX FSM states:
  - IDLE: if FIFO non-empty at an edge, pop the word and enter SHIFT.
  - SHIFT: ser_en_n=0 and ser_out=word[WORD_W-1-i] for cycle i (i = 0..WORD_W-1); exactly WORD_W cycles, then GAP.
  - GAP: ser_en_n=1 for IFG cycles. After the last gap cycle, enter SHIFT directly if the FIFO is non-empty (pop), otherwise IDLE.
- TX latency: a word accepted at edge k into an empty FIFO with the FSM in IDLE drives its first bit, with ser_en_n=0, after edge k+1.
- TX FIFO:
  - Push and pop in the same cycle is allowed when full: net level unchanged, tx_ready stays 0 that cycle. Likewise when empty: the pop happens only if the FIFO held data before the edge, so a push into an empty FIFO is not popped in that same cycle.
  - Pointers wrap modulo TX_DEPTH.
- RX bit counter: counts each cycle with ser_in_valid=1, shifting ser_in in at the LSB.
- RX word completion: on the WORD_W-th bit, the assembled word is transferred next edge to rx_data, rx_valid=1, rx_parity_err=PARITY_EN & ^word, and the counter is cleared.
- RX bits beyond a word: if ser_in_valid stays high, the next bit starts a new word (back-to-back words allowed).
- RX frame error: ser_in_valid=0 with counter in 1..WORD_W-1 gives rx_frame_err=1 for one cycle; partial word discarded, counter cleared.
- RX overrun: completion while rx_valid&&!rx_ready gives rx_overrun=1 for one cycle; the new word is dropped and old rx_data is kept.
- RX simultaneous accept and completion: rx_ready with rx_valid in the same cycle as completion loads the new word, rx_valid stays 1, no overrun.
- RX handshake: rx_valid clears the edge after rx_valid&&rx_ready with no new word.
- Independence: TX and RX are fully independent; simultaneous operation is required.

Decomposition:
- Package serial_link_pkg holds:
  - tx_state_t enum {TX_IDLE, TX_SHIFT, TX_GAP}.
  - function even_parity(bit vector) returning XOR reduction.
  - constant default ALU word width 10.
- Sub-module sync_fifo (parametrised width/depth, push/pop/full/empty/level) implements the TX buffer.
- The RX path stays inline.

Test Plan:
1. Reset then push 10'h0F0: after 1 cycle ser_en_n low for exactly 10 cycles, ser_out = 0,0,1,1,1,1,0,0,0,0, then ser_en_n high; tx_busy drops after the gap.
2. Push 6 words back-to-back with no stall, TX_DEPTH=4: tx_ready deasserts when the FIFO is full; the following words are taken when tx_ready reasserts, after pops. All 6 are transmitted in order, each separated by exactly IFG=1 high cycles of ser_en_n.
3. Loopback (ser_in=ser_out, ser_in_valid=~ser_en_n), rx_ready=1: sent 10'h0F0 and 10'h0F1 arrive as rx_data 10'h0F0 with rx_parity_err=0, then 10'h0F1 with rx_parity_err=1.
4. Drive ser_in_valid high for 4 cycles then low: rx_frame_err pulses once, rx_valid stays 0; a following full word is received correctly.
5. rx_ready=0, two complete words received: first held in rx_data, rx_overrun pulses on the second; the first word is read intact when rx_ready=1.
6. Assert rst for 1 cycle during bit 5 of a TX word with 2 words queued: ser_en_n=1 next cycle, tx_level=0, no further bits are driven, and RX outputs are cleared.
